button_debounce: RTL

- Conditions the raw push-button input for the test/oscillator logic: synchronises, debounces, and turns it into clean level and single-cycle event outputs.
- Outputs: debounced level, press and release pulses, long-press detection, and a wrapping press counter.
- Sits between the board button pin and consumers such as the LED/oscillator test logic, which take `press` instead of the raw `button`.

---
 rtl/button_debounce.sv | 129 ++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, counter debounce, press/release
// event pulses, long-press detection and a wrapping press counter.
// The release event port is named release_pulse because `release` is a reserved word.
module button_debounce #(
  parameter int unsigned OscF       = 24000000,
  parameter int unsigned DebCycles  = OscF / 100,
  parameter int unsigned LongCycles = OscF,
  parameter int unsigned CntW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            button,
  output logic            level,
  output logic            press,
  output logic            release_pulse,
  output logic            long_press,
  output logic            held_long,
  output logic [CntW-1:0] press_count
);

  localparam int unsigned DebN  = (DebCycles < 1) ? 1 : DebCycles;
  localparam int unsigned LongN = (LongCycles < 1) ? 1 : LongCycles;
  localparam int unsigned DebW  = $clog2(DebN + 1);
  localparam int unsigned HoldW = $clog2(LongN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  state_t            state, state_d;
  logic              s1, s2;
  logic [DebW-1:0]   deb_cnt, deb_cnt_d;
  logic [HoldW-1:0]  hold_cnt, hold_d;
  logic              level_d, press_d, release_d, long_d, held_d;
  logic [CntW-1:0]   count_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      state         <= IDLE;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      held_long     <= 1'b0;
      press_count   <= '0;
    end else begin
      s1            <= button;
      s2            <= s1;
      deb_cnt       <= deb_cnt_d;
      hold_cnt      <= hold_d;
      state         <= state_d;
      level         <= level_d;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      held_long     <= held_d;
      press_count   <= count_d;
    end
  end

  // Debounce, event generation and hold-tracking FSM
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = hold_cnt;
    state_d   = state;
    long_d    = 1'b0;
    held_d    = held_long & ~release_pulse;
    count_d   = press_count;

    // A new level is accepted only after DebN consecutive differing samples
    if (s2 != level) begin
      if (deb_cnt == DebW'(DebN - 1)) begin
        level_d   = s2;
        press_d   = s2;
        release_d = ~s2;
      end else begin
        deb_cnt_d = deb_cnt + DebW'(1);
      end
    end

    if (press_d) count_d = press_count + CntW'(1);

    case (state)
      IDLE: begin
        if (press_d) begin
          state_d = HELD;
          hold_d  = HoldW'(1);
        end
      end
      HELD: begin
        if (release_d) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_cnt != HoldW'(LongN)) begin
          hold_d = hold_cnt + HoldW'(1);
        end
      end
      LONG: begin
        // hold_cnt stays saturated at LongN until release
        if (release_d) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

    // Fires in the cycle the hold count first reads LongN (press cycle when LongN == 1)
    if (state_d == HELD && hold_d == HoldW'(LongN)) begin
      state_d = LONG;
      long_d  = 1'b1;
      held_d  = 1'b1;
    end
  end

endmodule
